// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
// Contents:
//   arb_state_e  - arbiter FSM state encoding (idle / bus cycle / response)
//   W_*          - access width codes as seen on m*_width and mem_width
//   RAM_SEL_BIT  - address bit that selects RAM (1) versus ROM (0)
//   access_err() - latch-time legality check (width, alignment, ROM write)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [1:0] W_BAD  = 2'b11;

  localparam int unsigned RAM_SEL_BIT = 31;

  // Returns 1 when the access must be refused without touching the bus.
  function automatic logic access_err(input logic        we,
                                      input logic [31:0] addr,
                                      input logic [1:0]  width);
    logic err;
    err = 1'b0;
    unique case (width)
      W_BYTE: err = 1'b0;
      W_HALF: err = addr[0];
      W_WORD: err = |addr[1:0];
      W_BAD:  err = 1'b1;
      default: err = 1'b1;
    endcase
    // ROM is read-only.
    if (we && !addr[RAM_SEL_BIT]) begin
      err = 1'b1;
    end
    return err;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker.
// Ports:
//   req        in  2  request vector, bit i = master i
//   last_grant in  1  index of the master granted most recently
//   grant      out 2  one-hot grant (all zero when no request)
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the master that was not served last wins.
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between requester m0 (core) and m1 (DMA/debug).
// One transaction at a time, round-robin on contention, refuses illegal
// accesses before the bus cycle, supports wait states via mem_ready and
// ends a stalled access with an error after TIMEOUT bus cycles.
// Ports:
//   clk, reset                   clock (rising edge), async active-low reset
//   mX_req/we/addr/width/wdata   request from master X, held until mX_ack
//   mX_rdata                     read data, updated when a read completes
//   mX_ack/mX_err                one-cycle completion pulse and its error flag
//   mem_addr/dout/width          downstream access, non-zero only in a bus cycle
//   mem_read_en/mem_write_en     downstream strobes
//   mem_din/mem_ready            downstream read data and completion
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [1:0]  m0_width,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [1:0]  m1_width,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_dout,
  input  logic [31:0] mem_din,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [1:0]  mem_width,
  input  logic        mem_ready
);

  arb_state_e       state_q;
  logic             last_grant_q;
  logic             sel_q;       // master owning the current transaction
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]  grant;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [1:0]  sel_width;
  logic [31:0] sel_wdata;

  rr_arbiter2 u_rr (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    sel_we    = grant[1] ? m1_we    : m0_we;
    sel_addr  = grant[1] ? m1_addr  : m0_addr;
    sel_width = grant[1] ? m1_width : m0_width;
    sel_wdata = grant[1] ? m1_wdata : m0_wdata;
  end

  // The mem_* output registers double as the latched address/width/data of
  // the transaction; they are loaded on entry to StBus and zeroed on exit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      mem_addr     <= '0;
      mem_dout     <= '0;
      mem_width    <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      m0_ack       <= 1'b0;
      m0_err       <= 1'b0;
      m1_ack       <= 1'b0;
      m1_err       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|grant) begin
            sel_q        <= grant[1];
            last_grant_q <= grant[1];
            we_q         <= sel_we;
            cnt_q        <= '0;
            if (access_err(sel_we, sel_addr, sel_width)) begin
              // Refused: answer straight away, never touch the bus.
              state_q <= StResp;
              m0_ack  <= ~grant[1];
              m0_err  <= ~grant[1];
              m1_ack  <= grant[1];
              m1_err  <= grant[1];
            end else begin
              state_q      <= StBus;
              mem_addr     <= sel_addr;
              mem_width    <= sel_width;
              mem_dout     <= sel_we ? sel_wdata : 32'h0;
              mem_read_en  <= ~sel_we;
              mem_write_en <= sel_we;
            end
          end
        end

        StBus: begin
          if (mem_ready || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
            state_q      <= StResp;
            mem_addr     <= '0;
            mem_dout     <= '0;
            mem_width    <= '0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            m0_ack       <= ~sel_q;
            m1_ack       <= sel_q;
            // Ready wins over timeout on the last allowed cycle.
            m0_err       <= ~sel_q & ~mem_ready;
            m1_err       <= sel_q & ~mem_ready;
            if (mem_ready && !we_q) begin
              if (sel_q) begin
                m1_rdata <= mem_din;
              end else begin
                m0_rdata <= mem_din;
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        StResp: begin
          state_q <= StIdle;
          m0_ack  <= 1'b0;
          m0_err  <= 1'b0;
          m1_ack  <= 1'b0;
          m1_err  <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
